// File: rtl/booth_seq_core_if.sv
// Bus between booth_seq_core and its environment: operand request
// handshake, Booth-table mux drive/return and product result.
//   start, multiplicand, multiplier : request and signed operands
//   booth_sel, seg0, seg1           : mux select and candidate segments
//   addend                          : selected mux output (0, +M or -M)
//   busy, done, product             : status and registered 2W-bit result
interface booth_seq_core_if #(
    parameter int unsigned Width = 16
);
    logic                   start;
    logic [Width-1:0]       multiplicand;
    logic [Width-1:0]       multiplier;
    logic [1:0]             booth_sel;
    logic [Width:0]         seg0;
    logic [Width:0]         seg1;
    logic [Width:0]         addend;
    logic                   busy;
    logic                   done;
    logic [2*Width-1:0]     product;

    // Environment side: issues requests and closes the mux loop.
    modport master (
        output start, multiplicand, multiplier, addend,
        input  booth_sel, seg0, seg1, busy, done, product
    );

    // Core side.
    modport slave (
        input  start, multiplicand, multiplier, addend,
        output booth_sel, seg0, seg1, busy, done, product
    );
endinterface

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth multiplier core.
// Drives an external Booth-table 4:1 mux (select plus +M / -M segments)
// and consumes its output as the per-iteration addend. Runs Width
// iterations of add + arithmetic shift, then presents the 2*Width-bit
// signed product with a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : booth_seq_core_if.slave (request, mux loop, status, product)
module booth_seq_core #(
    parameter int unsigned Width = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_seq_core_if.slave    bus
);
    localparam int unsigned CntW = $clog2(Width) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // A is one bit wider than the operands so -(-2^(W-1)) fits.
    logic [Width:0]      r_a;
    logic [Width-1:0]    r_q;
    logic                r_q1;
    logic [Width:0]      r_m;
    logic [CntW-1:0]     r_count;
    logic [2*Width-1:0]  r_product;
    logic                r_done;
    logic                r_busy;

    logic                w_accept;
    logic                w_last;
    logic [Width:0]      w_sum;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == RUN) && (r_count == CntW'(Width - 1));
    assign w_sum    = r_a + bus.addend;

    // Mux drive depends on registers only; no combinational path from addend.
    assign bus.booth_sel = {r_q[0], r_q1};
    assign bus.seg0      = r_m;
    assign bus.seg1      = -r_m;

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= w_last;
            r_busy <= w_accept || ((r_state == RUN) && !w_last);
            if (w_accept) begin
                r_a     <= '0;
                r_q     <= bus.multiplier;
                r_q1    <= 1'b0;
                r_m     <= {bus.multiplicand[Width-1], bus.multiplicand};
                r_count <= '0;
            end else if (r_state == RUN) begin
                // Arithmetic right shift of {sum, Q, Q_-1}, sum MSB replicated.
                r_a     <= {w_sum[Width], w_sum[Width:1]};
                r_q     <= {w_sum[0], r_q[Width-1:1]};
                r_q1    <= r_q[0];
                r_count <= r_count + CntW'(1);
                if (w_last) begin
                    // Low 2W bits of the shifted {A, Q}.
                    r_product <= {w_sum, r_q[Width-1:1]};
                end
            end
        end
    end
endmodule
